pp_hazard_ctrl: RTL and testbench
=================================

# pp_hazard_ctrl

Pipeline hazard controller for the instruction-list processor: the backward control path that pairs with the forward stage registers. It watches the control word leaving the execute-stage pipeline register, which carries branch and peripheral-access strobes. It drives stall (hold PC and stage registers) and flush (load a zero control bubble) back to the fetch/decode stages. It serializes taken-branch redirects and multi-cycle peripheral accesses (UART/SPI/timer-counter) that complete on a ready handshake.

## Interface
- FLUSH_DEPTH, 2: bubble cycles inserted after a taken branch; legal 1..7.
- TIMEOUT, 64: maximum WAIT cycles before a peripheral access is aborted; legal 2..255 (used only with PERIPH_TIMEOUT_EN).

- clk  in  1  processor clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- exBranch  in  1  execute-stage control word is a branch
- exTaken  in  1  branch condition true (from ALU/accumulator)
- exPeriphReq  in  1  OR of execute-stage uart read/write, spi buf read/write/shift, tc accesses
- periphReady  in  1  addressed peripheral completes the access this cycle
- errClr  in  1  clears timeoutErr and stallCnt
- stall  out  1  hold PC, ppReg1 and ppReg2 contents
- flush  out  1  ppReg2 loads all-zero control (bubble) next edge
- pcLoad  out  1  PC loads branch target next edge
- abort  out  1  one-cycle pulse: peripheral access abandoned
- timeoutErr  out  1  sticky timeout flag
- stallCnt  out  8  saturating count of stalled cycles

## Operation
- States: IDLE, WAIT, FLUSH. 3-bit flush counter fcnt, 8-bit wait counter wcnt.
- stall, flush, pcLoad, abort are combinational from state and inputs. Every other output is registered.
- br = exBranch & exTaken.
- IDLE:
  - exPeriphReq & !periphReady: stall=1; go WAIT; wcnt<=0.
  - Otherwise, if br: pcLoad=1, flush=1. If FLUSH_DEPTH>1, go FLUSH with fcnt<=FLUSH_DEPTH-2; otherwise stay IDLE.
  - Otherwise all strobes 0.
- WAIT:
  - While !periphReady: stall=1 and wcnt increments.
  - On periphReady: stall=0. If br is also true, apply the IDLE branch action this cycle; otherwise go IDLE. The stage registers are frozen, so br is the same held instruction.
- FLUSH:
  - flush=1, stall=0.
  - exPeriphReq and br are ignored, because bubbles carry zero control.
  - When fcnt==0 go IDLE; otherwise decrement fcnt.
- Simultaneous branch and peripheral request in IDLE with periphReady=1: the branch acts immediately and there is no stall.
- stallCnt increments on every cycle with stall=1 and saturates at 255. errClr has priority over the increment and clears it to 0.
- timeoutErr is set by abort and cleared by errClr. If both occur in the same cycle, set wins.

## Timing
- Reset (asynchronous, whenever reset=0): state=IDLE, fcnt=0, wcnt=0, timeoutErr=0, stallCnt=0, and therefore stall=flush=pcLoad=abort=0. Reset during WAIT releases stall immediately, without waiting for a clock.
- Taken-branch penalty is exactly FLUSH_DEPTH cycles of flush. pcLoad is high for exactly 1 cycle.
- Peripheral access with ready asserted k cycles after request: stall high for k cycles. k=0 gives no stall.
- No output depends on periphReady outside the WAIT and IDLE states.

## Configuration
- PERIPH_TIMEOUT_EN defined:
  - In WAIT, when wcnt==TIMEOUT-1 and !periphReady: abort=1 and stall=0 for that cycle, timeoutErr<=1, and the state goes to IDLE. The instruction retires without data.
  - If br is true in the same cycle, the branch action takes priority and abort still fires.
- PERIPH_TIMEOUT_EN undefined:
  - WAIT holds indefinitely.
  - abort and timeoutErr are tied to 0, the wcnt logic is removed, and TIMEOUT is ignored.

## Test plan
- Reset mid-WAIT: exPeriphReq=1, periphReady=0 for 3 cycles, then reset=0 asynchronously -> stall falls without a clock edge; after release all outputs are 0 and stallCnt=0.
- Taken branch, FLUSH_DEPTH=2: exBranch=exTaken=1 for 1 cycle -> pcLoad high 1 cycle; flush high cycles 0 and 1; IDLE by cycle 2. With exTaken=0 -> no strobes.
- Peripheral ready after 4 cycles: exPeriphReq=1, periphReady rises in cycle 4 -> stall high cycles 0–3 and low in cycle 4; stallCnt=4.
- Branch plus peripheral request, ready in cycle 2: stall cycles 0–1; in cycle 2 pcLoad=1 and flush=1, then FLUSH; stallCnt=2.
- Timeout, TIMEOUT=8, PERIPH_TIMEOUT_EN defined, periphReady held 0: stall cycles 0–7, abort pulse in cycle 8 with stall=0, timeoutErr=1; errClr -> timeoutErr=0 and stallCnt=0.
- Saturation: 300 consecutive stalled cycles without the macro -> stallCnt=255, abort never asserted.

Source files
------------

// File: rtl/pp_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pp_hazard_ctrl
//
// Pipeline hazard controller for the instruction-list processor.  Watches
// the control word leaving the execute-stage pipeline register and drives
// the backward stall/flush controls to fetch/decode.  It serializes
// taken-branch redirects (PC load plus FLUSH_DEPTH bubble cycles) and
// multi-cycle peripheral accesses that complete on a ready handshake.
//
// Parameters
//   FLUSH_DEPTH  bubble cycles inserted after a taken branch (1..7)
//   TIMEOUT      max WAIT cycles before a peripheral access is abandoned
//                (2..255, only meaningful with PERIPH_TIMEOUT_EN)
//
// Optional feature macro: PERIPH_TIMEOUT_EN
//   defined   : a WAIT that lasts TIMEOUT cycles is aborted, timeoutErr set
//   undefined : WAIT holds indefinitely, abort/timeoutErr tied low
//
// Ports
//   clk          processor clock, all state on rising edge
//   reset        asynchronous, active-low reset
//   exBranch     execute-stage control word is a branch
//   exTaken      branch condition true
//   exPeriphReq  execute-stage peripheral access request
//   periphReady  addressed peripheral completes the access this cycle
//   errClr       clears timeoutErr and stallCnt
//   stall        hold PC and stage registers (combinational)
//   flush        ppReg2 loads a zero bubble next edge (combinational)
//   pcLoad       PC loads branch target next edge (combinational)
//   abort        one-cycle pulse, peripheral access abandoned (combinational)
//   timeoutErr   sticky timeout flag (registered)
//   stallCnt     saturating count of stalled cycles (registered)
// ---------------------------------------------------------------------------
module pp_hazard_ctrl #(
    parameter int FLUSH_DEPTH = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       exBranch,
    input  logic       exTaken,
    input  logic       exPeriphReq,
    input  logic       periphReady,
    input  logic       errClr,
    output logic       stall,
    output logic       flush,
    output logic       pcLoad,
    output logic       abort,
    output logic       timeoutErr,
    output logic [7:0] stallCnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Counter reload for the FLUSH state: the branch cycle itself already
    // flushes once, so the FLUSH state covers the remaining FLUSH_DEPTH-1.
    localparam logic [2:0] FCNT_INIT = 3'(FLUSH_DEPTH - 2);

    // Elaboration-time guard against illegal parameter values.
    if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > 7 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_param
        $error("pp_hazard_ctrl: FLUSH_DEPTH or TIMEOUT out of legal range");
    end

    state_t     state_q, state_d;
    logic [2:0] fcnt_q, fcnt_d;
    logic [7:0] stall_cnt_q, stall_cnt_d;
    logic       br;
    logic       branch_go;

`ifdef PERIPH_TIMEOUT_EN
    localparam logic [7:0] WCNT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wcnt_q, wcnt_d;
    logic       timeout_err_q, timeout_err_d;
`endif

    assign br = exBranch & exTaken;

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            fcnt_q      <= 3'd0;
            stall_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

`ifdef PERIPH_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt_q        <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            wcnt_q        <= wcnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
`endif

    // Next-state and strobe logic.  A taken branch is resolved through
    // branch_go so that IDLE, a completing WAIT and a timed-out WAIT all
    // share one redirect action.
    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        stall     = 1'b0;
        flush     = 1'b0;
        pcLoad    = 1'b0;
        abort     = 1'b0;
        branch_go = 1'b0;
`ifdef PERIPH_TIMEOUT_EN
        wcnt_d    = wcnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (exPeriphReq && !periphReady) begin
                    stall   = 1'b1;
                    state_d = ST_WAIT;
`ifdef PERIPH_TIMEOUT_EN
                    wcnt_d  = 8'd0;
`endif
                end else if (br) begin
                    branch_go = 1'b1;
                end
            end

            ST_WAIT: begin
                // Stage registers are frozen here, so br still describes
                // the held instruction that issued the access.
                if (periphReady) begin
                    if (br) begin
                        branch_go = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
`ifdef PERIPH_TIMEOUT_EN
                end else if (wcnt_q == WCNT_LAST) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                    if (br) begin
                        branch_go = 1'b1;
                    end
`endif
                end else begin
                    stall  = 1'b1;
`ifdef PERIPH_TIMEOUT_EN
                    wcnt_d = wcnt_q + 8'd1;
`endif
                end
            end

            ST_FLUSH: begin
                // Bubbles carry zero control, so requests are ignored here.
                flush = 1'b1;
                if (fcnt_q == 3'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (branch_go) begin
            pcLoad = 1'b1;
            flush  = 1'b1;
            if (FLUSH_DEPTH > 1) begin
                state_d = ST_FLUSH;
                fcnt_d  = FCNT_INIT;
            end else begin
                state_d = ST_IDLE;
            end
        end

        // Strobes are quiet for as long as reset is held, even if the
        // execute-stage inputs are still requesting.
        if (!reset) begin
            stall  = 1'b0;
            flush  = 1'b0;
            pcLoad = 1'b0;
            abort  = 1'b0;
        end
    end

    // Stall counter: clear wins over the saturating increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (errClr) begin
            stall_cnt_d = 8'd0;
        end else if (stall && stall_cnt_q != 8'hFF) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

`ifdef PERIPH_TIMEOUT_EN
    // Sticky timeout flag: a new abort wins over a simultaneous clear.
    always_comb begin
        timeout_err_d = timeout_err_q;
        if (abort) begin
            timeout_err_d = 1'b1;
        end else if (errClr) begin
            timeout_err_d = 1'b0;
        end
    end

    assign timeoutErr = timeout_err_q;
`else
    assign timeoutErr = 1'b0;
`endif

    assign stallCnt = stall_cnt_q;

endmodule

// File: tb/tb_pp_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pp_hazard_ctrl
//
// Directed self-checking bench for pp_hazard_ctrl with FLUSH_DEPTH=2 and
// TIMEOUT=8.  Inputs change 1ns after a rising edge; outputs are sampled
// on the falling edge.  The timeout scenario runs when PERIPH_TIMEOUT_EN is
// defined, the saturation scenario when it is not.
// ---------------------------------------------------------------------------
module tb_pp_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       exBranch;
    logic       exTaken;
    logic       exPeriphReq;
    logic       periphReady;
    logic       errClr;
    logic       stall;
    logic       flush;
    logic       pcLoad;
    logic       abort;
    logic       timeoutErr;
    logic [7:0] stallCnt;

    int testsRun;
    int testsFailed;

    pp_hazard_ctrl #(
        .FLUSH_DEPTH(2),
        .TIMEOUT    (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .exBranch   (exBranch),
        .exTaken    (exTaken),
        .exPeriphReq(exPeriphReq),
        .periphReady(periphReady),
        .errClr     (errClr),
        .stall      (stall),
        .flush      (flush),
        .pcLoad     (pcLoad),
        .abort      (abort),
        .timeoutErr (timeoutErr),
        .stallCnt   (stallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic br, input logic tk, input logic req,
                                 input logic rdy, input logic clr);
        exBranch    = br;
        exTaken     = tk;
        exPeriphReq = req;
        periphReady = rdy;
        errClr      = clr;
    endtask

    // One idle cycle with errClr to start each scenario from stallCnt=0.
    task automatic clearCounters();
        applyStimulus(0, 0, 0, 0, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        #2;
        testsRun++;
        if ({stall, flush, pcLoad, abort, timeoutErr} !== 5'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_strobes: got %b want 00000",
                     {stall, flush, pcLoad, abort, timeoutErr});
        end
        testsRun++;
        if (stallCnt !== 8'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_stallCnt: got %0d want 0", stallCnt);
        end
        @(negedge clk);
        reset = 1'b1;
        nextCycle();
    endtask

    task automatic test_branch();
        clearCounters();
        applyStimulus(1, 1, 0, 0, 0);
        @(negedge clk);
        testsRun++;
        if ({pcLoad, flush, stall} !== 3'b110) begin
            testsFailed++;
            $display("[TB] FAIL branch_c0: pcLoad/flush/stall got %b want 110",
                     {pcLoad, flush, stall});
        end
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        testsRun++;
        if ({pcLoad, flush, stall} !== 3'b010) begin
            testsFailed++;
            $display("[TB] FAIL branch_c1: pcLoad/flush/stall got %b want 010",
                     {pcLoad, flush, stall});
        end
        nextCycle();
        @(negedge clk);
        testsRun++;
        if ({pcLoad, flush, stall} !== 3'b000) begin
            testsFailed++;
            $display("[TB] FAIL branch_c2: pcLoad/flush/stall got %b want 000",
                     {pcLoad, flush, stall});
        end
        // Not-taken branch: no strobes in that cycle or the next.
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            testsRun++;
            if ({pcLoad, flush, stall} !== 3'b000) begin
                testsFailed++;
                $display("[TB] FAIL branch_nottaken_c%0d: got %b want 000",
                         c, {pcLoad, flush, stall});
            end
            nextCycle();
        end
        applyStimulus(0, 0, 0, 0, 0);
    endtask

    task automatic test_periph_wait();
        clearCounters();
        for (int c = 0; c < 5; c++) begin
            applyStimulus(0, 0, 1, (c == 4), 0);
            @(negedge clk);
            testsRun++;
            if (stall !== (c < 4)) begin
                testsFailed++;
                $display("[TB] FAIL periph_stall_c%0d: got %b want %b", c, stall, (c < 4));
            end
            nextCycle();
        end
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        testsRun++;
        if (stallCnt !== 8'd4) begin
            testsFailed++;
            $display("[TB] FAIL periph_stallCnt: got %0d want 4", stallCnt);
        end
        testsRun++;
        if ({stall, flush, pcLoad} !== 3'b000) begin
            testsFailed++;
            $display("[TB] FAIL periph_idle: got %b want 000", {stall, flush, pcLoad});
        end
        nextCycle();
    endtask

    task automatic test_branch_periph();
        clearCounters();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1, 1, 1, (c == 2), 0);
            @(negedge clk);
            testsRun++;
            if ({stall, pcLoad, flush} !== ((c < 2) ? 3'b100 : 3'b011)) begin
                testsFailed++;
                $display("[TB] FAIL brperiph_c%0d: stall/pcLoad/flush got %b want %b",
                         c, {stall, pcLoad, flush}, ((c < 2) ? 3'b100 : 3'b011));
            end
            nextCycle();
        end
        // In FLUSH the still-asserted request and branch must be ignored.
        applyStimulus(1, 1, 1, 0, 0);
        @(negedge clk);
        testsRun++;
        if ({stall, pcLoad, flush} !== 3'b001) begin
            testsFailed++;
            $display("[TB] FAIL brperiph_flush: stall/pcLoad/flush got %b want 001",
                     {stall, pcLoad, flush});
        end
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        testsRun++;
        if ({stall, pcLoad, flush} !== 3'b000) begin
            testsFailed++;
            $display("[TB] FAIL brperiph_done: got %b want 000", {stall, pcLoad, flush});
        end
        testsRun++;
        if (stallCnt !== 8'd2) begin
            testsFailed++;
            $display("[TB] FAIL brperiph_stallCnt: got %0d want 2", stallCnt);
        end
        nextCycle();
    endtask

    task automatic test_simultaneous();
        clearCounters();
        applyStimulus(1, 1, 1, 1, 0);
        @(negedge clk);
        testsRun++;
        if ({stall, pcLoad, flush} !== 3'b011) begin
            testsFailed++;
            $display("[TB] FAIL simult_c0: stall/pcLoad/flush got %b want 011",
                     {stall, pcLoad, flush});
        end
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        nextCycle();
        @(negedge clk);
        testsRun++;
        if ({stall, pcLoad, flush} !== 3'b000 || stallCnt !== 8'd0) begin
            testsFailed++;
            $display("[TB] FAIL simult_end: strobes %b cnt %0d want 000 cnt 0",
                     {stall, pcLoad, flush}, stallCnt);
        end
        nextCycle();
    endtask

`ifdef PERIPH_TIMEOUT_EN
    task automatic test_timeout();
        clearCounters();
        for (int c = 0; c < 9; c++) begin
            applyStimulus(0, 0, 1, 0, 0);
            @(negedge clk);
            testsRun++;
            if ({stall, abort} !== ((c < 8) ? 2'b10 : 2'b01)) begin
                testsFailed++;
                $display("[TB] FAIL timeout_c%0d: stall/abort got %b want %b",
                         c, {stall, abort}, ((c < 8) ? 2'b10 : 2'b01));
            end
            nextCycle();
        end
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        testsRun++;
        if ({timeoutErr, abort} !== 2'b10 || stallCnt !== 8'd8) begin
            testsFailed++;
            $display("[TB] FAIL timeout_flag: err/abort %b cnt %0d want 10 cnt 8",
                     {timeoutErr, abort}, stallCnt);
        end
        nextCycle();
        applyStimulus(0, 0, 0, 0, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        testsRun++;
        if (timeoutErr !== 1'b0 || stallCnt !== 8'd0) begin
            testsFailed++;
            $display("[TB] FAIL timeout_clear: err %b cnt %0d want 0 cnt 0",
                     timeoutErr, stallCnt);
        end
        nextCycle();
    endtask
`else
    task automatic test_saturation();
        int abortSeen;
        abortSeen = 0;
        clearCounters();
        applyStimulus(0, 0, 1, 0, 0);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (abort !== 1'b0) abortSeen++;
            nextCycle();
        end
        @(negedge clk);
        testsRun++;
        if (stallCnt !== 8'd255) begin
            testsFailed++;
            $display("[TB] FAIL sat_stallCnt: got %0d want 255", stallCnt);
        end
        testsRun++;
        if (abortSeen !== 0 || stall !== 1'b1 || timeoutErr !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL sat_hold: abortSeen %0d stall %b err %b want 0 1 0",
                     abortSeen, stall, timeoutErr);
        end
        applyStimulus(0, 0, 1, 1, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        nextCycle();
    endtask
`endif

    task automatic test_reset_mid_wait();
        clearCounters();
        applyStimulus(0, 0, 1, 0, 0);
        nextCycle();
        nextCycle();
        @(negedge clk);
        testsRun++;
        if (stall !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL rstwait_pre: stall got %b want 1", stall);
        end
        // Assert reset between edges and look before the next rising edge.
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        testsRun++;
        if ({stall, flush, pcLoad, abort} !== 4'b0 || stallCnt !== 8'd0) begin
            testsFailed++;
            $display("[TB] FAIL rstwait_async: strobes %b cnt %0d want 0000 cnt 0",
                     {stall, flush, pcLoad, abort}, stallCnt);
        end
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        nextCycle();
        @(negedge clk);
        testsRun++;
        if ({stall, flush, pcLoad, abort, timeoutErr} !== 5'b0 || stallCnt !== 8'd0) begin
            testsFailed++;
            $display("[TB] FAIL rstwait_after: strobes %b cnt %0d want 00000 cnt 0",
                     {stall, flush, pcLoad, abort, timeoutErr}, stallCnt);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        test_reset();
        test_branch();
        test_periph_wait();
        test_branch_periph();
        test_simultaneous();
`ifdef PERIPH_TIMEOUT_EN
        test_timeout();
`else
        test_saturation();
`endif
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
